// File: rtl/video_timing_pkg.sv
// Shared types, default timing and helpers for the video timing generator.
//   pos_t      : 9-bit counter type for hcnt/vcnt and sync window bounds
//   adj_t      : signed 4-bit sync shift used when VIDEO_TIMING_ADJ_EN is defined
//   Taito*     : default Taito F2 raster (424x262, 320x224 visible, /8 pixel clock)
//   wrap_pos   : base + signed offset, wrapped into 0..total-1
//   in_window  : half-open window test that also handles a window wrapping past zero
package video_timing_pkg;

  typedef logic [8:0]        pos_t;
  typedef logic signed [3:0] adj_t;

  localparam int unsigned TaitoCeNum    = 1;
  localparam int unsigned TaitoCeDen    = 8;
  localparam int unsigned TaitoHTotal   = 424;
  localparam int unsigned TaitoHVisible = 320;
  localparam int unsigned TaitoHsStart  = 352;
  localparam int unsigned TaitoHsEnd    = 384;
  localparam int unsigned TaitoVTotal   = 262;
  localparam int unsigned TaitoVVisible = 224;
  localparam int unsigned TaitoVsStart  = 240;
  localparam int unsigned TaitoVsEnd    = 243;

  function automatic pos_t wrap_pos(pos_t base, adj_t offs, pos_t total);
    int s;
    // Truncating % leaves a negative remainder for negative sums; fold it back up.
    s = (int'(base) + int'(offs)) % int'(total);
    if (s < 0) s = s + int'(total);
    return pos_t'(s);
  endfunction

  function automatic logic in_window(pos_t pos, pos_t lo, pos_t hi);
    if (lo <= hi) return (pos >= lo) && (pos < hi);
    return (pos >= lo) || (pos < hi);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle from video_timing_gen to the downstream video stages.
//   ce_pix, hcnt, vcnt, hs, vs, hb, vb : raster timing (video_path consumes these as-is)
//   line_start, frame_start, vblank_irq : one-clk event pulses aligned with ce_pix
//   adj_h, adj_v : signed sync shifts into the generator (only with VIDEO_TIMING_ADJ_EN)
// master: the generator; slave: a consumer.
interface video_timing_if;
  import video_timing_pkg::*;

  logic ce_pix;
  pos_t hcnt;
  pos_t vcnt;
  logic hs;
  logic vs;
  logic hb;
  logic vb;
  logic line_start;
  logic frame_start;
  logic vblank_irq;

`ifdef VIDEO_TIMING_ADJ_EN
  adj_t adj_h;
  adj_t adj_v;

  modport master (
    output ce_pix, hcnt, vcnt, hs, vs, hb, vb, line_start, frame_start, vblank_irq,
    input  adj_h, adj_v
  );
  modport slave (
    input  ce_pix, hcnt, vcnt, hs, vs, hb, vb, line_start, frame_start, vblank_irq,
    output adj_h, adj_v
  );
`else
  modport master (
    output ce_pix, hcnt, vcnt, hs, vs, hb, vb, line_start, frame_start, vblank_irq
  );
  modport slave (
    input  ce_pix, hcnt, vcnt, hs, vs, hb, vb, line_start, frame_start, vblank_irq
  );
`endif

endinterface

// File: rtl/video_timing_gen_ce_frac_div.sv
// Fractional clock-enable divider: tick averages CE_NUM pulses per CE_DEN clocks.
//   clk   : system/video clock
//   reset : synchronous, active-high; clears the accumulator
//   tick  : combinational strobe, high in the clk whose accumulation reaches CE_DEN
// Requires CE_NUM < CE_DEN.
module ce_frac_div #(
  parameter int unsigned CE_NUM = 1,
  parameter int unsigned CE_DEN = 8
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // Wide enough for acc + CE_NUM (at most CE_DEN + CE_NUM - 1), never under 4 bits.
  localparam int unsigned AccW = ($clog2(CE_NUM + CE_DEN) < 4) ? 4 : $clog2(CE_NUM + CE_DEN);

  logic [AccW-1:0] acc_q, acc_d, acc_sum;

  always_comb begin
    acc_sum = acc_q + AccW'(CE_NUM);
    acc_d   = acc_sum;
    tick    = 1'b0;
    if (acc_sum >= AccW'(CE_DEN)) begin
      acc_d = acc_sum - AccW'(CE_DEN);
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raw core video timing: pixel enable, H/V counters, sync/blank and event pulses.
//   clk   : system/video clock
//   reset : synchronous, active-high; restarts the raster at pixel (0,0)
//   vt    : video_timing_if master (all timing outputs, adj inputs when enabled)
// All outputs are registered and change only in the clk where ce_pix is high.
// Optional VIDEO_TIMING_ADJ_EN: adj_h/adj_v shift the HS/VS windows (modulo the
// totals), sampled once per frame at frame_start.
module video_timing_gen import video_timing_pkg::*; #(
  parameter int unsigned CE_NUM    = TaitoCeNum,
  parameter int unsigned CE_DEN    = TaitoCeDen,
  parameter int unsigned H_TOTAL   = TaitoHTotal,
  parameter int unsigned H_VISIBLE = TaitoHVisible,
  parameter int unsigned HS_START  = TaitoHsStart,
  parameter int unsigned HS_END    = TaitoHsEnd,
  parameter int unsigned V_TOTAL   = TaitoVTotal,
  parameter int unsigned V_VISIBLE = TaitoVVisible,
  parameter int unsigned VS_START  = TaitoVsStart,
  parameter int unsigned VS_END    = TaitoVsEnd
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vt
);

  typedef enum logic [0:0] {StStart, StRun} state_e;

  logic   tick;
  state_e state_q, state_d;
  pos_t   hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic   ce_q, hs_q, vs_q, hb_q, vb_q, line_q, frame_q, virq_q;
  logic   line_hit, frame_hit;
  pos_t   hs_lo, hs_hi, vs_lo, vs_hi;

  ce_frac_div #(
    .CE_NUM (CE_NUM),
    .CE_DEN (CE_DEN)
  ) u_ce_frac_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // StStart: the first tick after reset lands on (0,0) instead of advancing to (1,0).
  always_ff @(posedge clk) begin
    if (reset) state_q <= StStart;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) state_d = StRun;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      unique case (state_q)
        StStart: begin
          hcnt_d = '0;
          vcnt_d = '0;
        end
        StRun: begin
          if (hcnt_q == pos_t'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == pos_t'(V_TOTAL - 1)) ? '0 : vcnt_q + 9'd1;
          end else begin
            hcnt_d = hcnt_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign line_hit  = tick && (hcnt_d == '0);
  assign frame_hit = line_hit && (vcnt_d == '0);

`ifdef VIDEO_TIMING_ADJ_EN
  adj_t adj_h_q, adj_v_q, adj_h_use, adj_v_use;

  // The new offsets already apply to the frame that frame_hit opens.
  assign adj_h_use = frame_hit ? vt.adj_h : adj_h_q;
  assign adj_v_use = frame_hit ? vt.adj_v : adj_v_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      adj_h_q <= '0;
      adj_v_q <= '0;
    end else if (frame_hit) begin
      adj_h_q <= vt.adj_h;
      adj_v_q <= vt.adj_v;
    end
  end

  assign hs_lo = wrap_pos(pos_t'(HS_START), adj_h_use, pos_t'(H_TOTAL));
  assign hs_hi = wrap_pos(pos_t'(HS_END),   adj_h_use, pos_t'(H_TOTAL));
  assign vs_lo = wrap_pos(pos_t'(VS_START), adj_v_use, pos_t'(V_TOTAL));
  assign vs_hi = wrap_pos(pos_t'(VS_END),   adj_v_use, pos_t'(V_TOTAL));
`else
  assign hs_lo = pos_t'(HS_START);
  assign hs_hi = pos_t'(HS_END);
  assign vs_lo = pos_t'(VS_START);
  assign vs_hi = pos_t'(VS_END);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      ce_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      virq_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      ce_q    <= tick;
      line_q  <= line_hit;
      frame_q <= frame_hit;
      virq_q  <= line_hit && (vcnt_d == pos_t'(V_VISIBLE));
      if (tick) begin
        hb_q <= hcnt_d >= pos_t'(H_VISIBLE);
        vb_q <= vcnt_d >= pos_t'(V_VISIBLE);
        hs_q <= in_window(hcnt_d, hs_lo, hs_hi);
        vs_q <= in_window(vcnt_d, vs_lo, vs_hi);
      end
    end
  end

  assign vt.ce_pix      = ce_q;
  assign vt.hcnt        = hcnt_q;
  assign vt.vcnt        = vcnt_q;
  assign vt.hs          = hs_q;
  assign vt.vs          = vs_q;
  assign vt.hb          = hb_q;
  assign vt.vb          = vb_q;
  assign vt.line_start  = line_q;
  assign vt.frame_start = frame_q;
  assign vt.vblank_irq  = virq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: several parameterisations run side by side, each
// compared every clk against a raster model computed from the clk count.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct packed {
    int num; int den; int ht; int hv; int hs0; int hs1; int vt; int vv; int vs0; int vs1;
  } cfg_t;

  localparam cfg_t CfgDef = '{num:1, den:8,  ht:424, hv:320, hs0:352, hs1:384,
                              vt:262, vv:224, vs0:240, vs1:243};
  localparam cfg_t CfgSml = '{num:1, den:3,  ht:20,  hv:12,  hs0:14,  hs1:17,
                              vt:10,  vv:6,   vs0:7,   vs1:9};
  localparam cfg_t CfgFrc = '{num:2, den:15, ht:424, hv:320, hs0:352, hs1:384,
                              vt:262, vv:224, vs0:240, vs1:243};
  localparam cfg_t CfgAdj = '{num:1, den:2,  ht:424, hv:320, hs0:352, hs1:384,
                              vt:4,   vv:2,   vs0:2,   vs1:3};
  localparam cfg_t CfgAdw = '{num:1, den:2,  ht:424, hv:320, hs0:352, hs1:420,
                              vt:4,   vv:2,   vs0:2,   vs1:3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic win(int x, int lo, int len, int tot);
    return ((((x - lo) % tot) + tot) % tot) < len;
  endfunction

  // n = clks since reset release; k = pixels emitted so far; pixel k-1 is the raster
  // position (row-major from (0,0)). Layout {ce,h,v,hs,vs,hb,vb,ls,fs,vi}.
  function automatic logic [25:0] model(cfg_t c, int n, int ah, int av);
    int k, kp, h, v;
    logic ce;
    if (n <= 0) return '0;
    k  = (n * c.num) / c.den;
    kp = ((n - 1) * c.num) / c.den;
    if (k == 0) return '0;
    h  = (k - 1) % c.ht;
    v  = ((k - 1) / c.ht) % c.vt;
    ce = (k != kp);
    return {ce, 9'(h), 9'(v),
            win(h, c.hs0 + ah, c.hs1 - c.hs0, c.ht), win(v, c.vs0 + av, c.vs1 - c.vs0, c.vt),
            h >= c.hv, v >= c.vv,
            ce && h == 0, ce && h == 0 && v == 0, ce && h == 0 && v == c.vv};
  endfunction

  logic rst_def = 1'b1, rst_sml = 1'b1, rst_frc = 1'b1, rst_adj = 1'b1, rst_adw = 1'b1;

  video_timing_if if_def ();
  video_timing_if if_sml ();
  video_timing_if if_frc ();

  video_timing_gen u_def (.clk(clk), .reset(rst_def), .vt(if_def));

  video_timing_gen #(
    .CE_NUM(1), .CE_DEN(3), .H_TOTAL(20), .H_VISIBLE(12), .HS_START(14), .HS_END(17),
    .V_TOTAL(10), .V_VISIBLE(6), .VS_START(7), .VS_END(9)
  ) u_sml (.clk(clk), .reset(rst_sml), .vt(if_sml));

  video_timing_gen #(.CE_NUM(2), .CE_DEN(15)) u_frc (.clk(clk), .reset(rst_frc), .vt(if_frc));

  logic [25:0] obs_def, obs_sml, obs_frc;
  assign obs_def = {if_def.ce_pix, if_def.hcnt, if_def.vcnt, if_def.hs, if_def.vs, if_def.hb,
                    if_def.vb, if_def.line_start, if_def.frame_start, if_def.vblank_irq};
  assign obs_sml = {if_sml.ce_pix, if_sml.hcnt, if_sml.vcnt, if_sml.hs, if_sml.vs, if_sml.hb,
                    if_sml.vb, if_sml.line_start, if_sml.frame_start, if_sml.vblank_irq};
  assign obs_frc = {if_frc.ce_pix, if_frc.hcnt, if_frc.vcnt, if_frc.hs, if_frc.vs, if_frc.hb,
                    if_frc.vb, if_frc.line_start, if_frc.frame_start, if_frc.vblank_irq};

`ifdef VIDEO_TIMING_ADJ_EN
  logic signed [3:0] adj_h_a = '0, adj_v_a = '0, adj_h_w = 4'sd7;
  int eff_h_a = 0, eff_v_a = 0, eff_h_w = 0;
  int adj_frames = 0, adj_hs_cnt = 0, adw_frames = 0;
  logic adj_hs_prev = 1'b0;

  video_timing_if if_adj ();
  video_timing_if if_adw ();

  assign if_def.adj_h = '0;
  assign if_def.adj_v = '0;
  assign if_sml.adj_h = '0;
  assign if_sml.adj_v = '0;
  assign if_frc.adj_h = '0;
  assign if_frc.adj_v = '0;
  assign if_adj.adj_h = adj_h_a;
  assign if_adj.adj_v = adj_v_a;
  assign if_adw.adj_h = adj_h_w;
  assign if_adw.adj_v = '0;

  video_timing_gen #(
    .CE_NUM(1), .CE_DEN(2), .V_TOTAL(4), .V_VISIBLE(2), .VS_START(2), .VS_END(3)
  ) u_adj (.clk(clk), .reset(rst_adj), .vt(if_adj));

  video_timing_gen #(
    .CE_NUM(1), .CE_DEN(2), .HS_END(420), .V_TOTAL(4), .V_VISIBLE(2), .VS_START(2), .VS_END(3)
  ) u_adw (.clk(clk), .reset(rst_adw), .vt(if_adw));

  logic [25:0] obs_adj, obs_adw;
  assign obs_adj = {if_adj.ce_pix, if_adj.hcnt, if_adj.vcnt, if_adj.hs, if_adj.vs, if_adj.hb,
                    if_adj.vb, if_adj.line_start, if_adj.frame_start, if_adj.vblank_irq};
  assign obs_adw = {if_adw.ce_pix, if_adw.hcnt, if_adw.vcnt, if_adw.hs, if_adw.vs, if_adw.hb,
                    if_adw.vb, if_adw.line_start, if_adw.frame_start, if_adw.vblank_irq};
`endif

  int n_def = 0, n_sml = 0, n_frc = 0, n_adj = 0, n_adw = 0;
  logic [25:0] exp_sml;

  int def_ce_cnt = 0, def_last = 0, def_hb_cnt = 0, def_hs_cnt = 0;
  logic def_hb_seen = 1'b0, def_hs_seen = 1'b0, def_line_done = 1'b0;

  int sml_frames = 0, sml_ce = 0, sml_ls = 0, sml_fs = 0, sml_vi = 0, sml_hmax = 0, sml_vmax = 0;
  logic sml_done = 1'b0;

  int frc_ticks = 0, frc_last = 0, frc_prev_sp = 0;

  task automatic step();
    logic [25:0] e;
    int sp;
    @(posedge clk);
    #1;

    n_def = rst_def ? 0 : n_def + 1;
    e = model(CfgDef, n_def, 0, 0);
    check_eq("def", obs_def, e);
    if (!rst_def && if_def.ce_pix) begin
      if (def_ce_cnt == 0) begin
        check_eq("def_first_ce", n_def, 8);
        check_eq("def_first_fs", if_def.frame_start, 1);
      end else if (def_ce_cnt == 1) begin
        check_eq("def_period", n_def - def_last, 8);
      end
      def_ce_cnt++;
      def_last = n_def;
      if (if_def.vcnt == 9'd1) begin
        if (if_def.hb && !def_hb_seen) begin
          def_hb_seen = 1'b1;
          check_eq("def_hb_start", if_def.hcnt, 320);
        end
        if (if_def.hs && !def_hs_seen) begin
          def_hs_seen = 1'b1;
          check_eq("def_hs_start", if_def.hcnt, 352);
        end
        def_hb_cnt += int'(if_def.hb);
        def_hs_cnt += int'(if_def.hs);
      end else if (if_def.vcnt == 9'd2 && !def_line_done) begin
        def_line_done = 1'b1;
        check_eq("def_hb_len", def_hb_cnt, 104);
        check_eq("def_hs_len", def_hs_cnt, 32);
      end
    end

    n_sml = rst_sml ? 0 : n_sml + 1;
    exp_sml = model(CfgSml, n_sml, 0, 0);
    check_eq("sml", obs_sml, exp_sml);
    if (!sml_done && if_sml.ce_pix) begin
      if (if_sml.frame_start) sml_frames++;
      if (sml_frames == 2) begin
        sml_done = 1'b1;
        check_eq("sml_frame_ce", sml_ce, 200);
        check_eq("sml_frame_ls", sml_ls, 10);
        check_eq("sml_frame_fs", sml_fs, 1);
        check_eq("sml_frame_vi", sml_vi, 1);
        check_eq("sml_hmax", sml_hmax, 19);
        check_eq("sml_vmax", sml_vmax, 9);
      end else if (sml_frames == 1) begin
        sml_ce++;
        sml_ls += int'(if_sml.line_start);
        sml_fs += int'(if_sml.frame_start);
        if (if_sml.vblank_irq) begin
          sml_vi++;
          check_eq("sml_vi_line", if_sml.vcnt, 6);
        end
        if (int'(if_sml.hcnt) > sml_hmax) sml_hmax = int'(if_sml.hcnt);
        if (int'(if_sml.vcnt) > sml_vmax) sml_vmax = int'(if_sml.vcnt);
      end
    end

    n_frc = rst_frc ? 0 : n_frc + 1;
    e = model(CfgFrc, n_frc, 0, 0);
    check_eq("frc", obs_frc, e);
    if (!rst_frc && if_frc.ce_pix && n_frc <= 1500) begin
      frc_ticks++;
      sp = n_frc - frc_last;
      if (frc_last == 0) check_eq("frc_first", sp, 8);
      else check_eq("frc_spacing", (sp == 7 || sp == 8) && sp != frc_prev_sp, 1);
      frc_prev_sp = sp;
      frc_last = n_frc;
    end

`ifdef VIDEO_TIMING_ADJ_EN
    n_adj = rst_adj ? 0 : n_adj + 1;
    e = model(CfgAdj, n_adj, eff_h_a, eff_v_a);
    if (e[1]) begin
      eff_h_a = int'(adj_h_a);
      eff_v_a = int'(adj_v_a);
      e = model(CfgAdj, n_adj, eff_h_a, eff_v_a);
    end
    check_eq("adj", obs_adj, e);
    if (if_adj.ce_pix) begin
      if (if_adj.frame_start) adj_frames++;
      if (if_adj.hs && !adj_hs_prev && adj_frames == 1 && if_adj.vcnt == 9'd1)
        check_eq("adj_hold", if_adj.hcnt, 352);
      if (if_adj.hs && !adj_hs_prev && adj_frames == 2 && if_adj.vcnt == 9'd0)
        check_eq("adj_new", if_adj.hcnt, 348);
      if (adj_frames == 2 && if_adj.vcnt == 9'd0) adj_hs_cnt += int'(if_adj.hs);
      if (adj_frames == 2 && if_adj.vcnt == 9'd1 && if_adj.hcnt == 9'd0)
        check_eq("adj_new_len", adj_hs_cnt, 32);
      adj_hs_prev = if_adj.hs;
    end

    n_adw = rst_adw ? 0 : n_adw + 1;
    e = model(CfgAdw, n_adw, eff_h_w, 0);
    if (e[1]) begin
      eff_h_w = int'(adj_h_w);
      e = model(CfgAdw, n_adw, eff_h_w, 0);
    end
    check_eq("adw", obs_adw, e);
    if (if_adw.ce_pix) begin
      if (if_adw.frame_start) adw_frames++;
      if (adw_frames == 1 && if_adw.vcnt == 9'd0 && if_adw.hcnt <= 9'd3)
        check_eq("adw_wrap", if_adw.hs, if_adw.hcnt < 9'd3);
    end
`endif
  endtask

  initial begin
    logic found;
    repeat (3) step();
    rst_def = 1'b0;
    rst_sml = 1'b0;
    rst_frc = 1'b0;
    rst_adj = 1'b0;
    rst_adw = 1'b0;
    repeat (1500) step();
    check_eq("frc_ticks", frc_ticks, 200);
`ifdef VIDEO_TIMING_ADJ_EN
    adj_h_a = -4'sd4;
`endif

    // Mid-frame reset on the small raster.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (exp_sml[24:16] == 9'd5 && exp_sml[15:7] == 9'd4) found = 1'b1;
    end
    check_eq("sml_find_mid", found, 1);
    rst_sml = 1'b1;
    step();
    check_eq("sml_rst_zero", obs_sml, 0);
    rst_sml = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_sml.ce_pix) found = 1'b1;
    end
    check_eq("sml_rst_ce", found, 1);
    check_eq("sml_rst_pos", {if_sml.hcnt, if_sml.vcnt, if_sml.frame_start}, 19'h1);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(50, 700)) step();
      rst_sml = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rst_sml = 1'b0;
`ifdef VIDEO_TIMING_ADJ_EN
      adj_v_a = 4'($urandom_range(0, 15));
`endif
    end

    repeat (4000) step();

    check_eq("def_line_seen", def_line_done, 1);
    check_eq("sml_frame_seen", sml_done, 1);
`ifdef VIDEO_TIMING_ADJ_EN
    check_eq("adj_frames_seen", adj_frames >= 3, 1);
    check_eq("adw_frames_seen", adw_frames >= 1, 1);
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
